// File: rtl/spu_dmem.sv
// Shared 256 x 16 data memory for the spu, with a host side-port and a
// hardware zero-fill sequencer. Priority each cycle: clear, host, spu.
module spu_dmem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [DATA_W-1:0] dm_w_data,
  output logic [DATA_W-1:0] dm_r_data,
  input  logic              host_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_rd,
  input  logic              host_wr,
  input  logic [DATA_W-1:0] host_w_data,
  output logic [DATA_W-1:0] host_r_data,
  output logic              host_r_valid,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              dm_err,
  input  logic              err_clr
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              clr_we;
  logic              spu_own;
  logic              host_own;
  logic              dm_drop;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (cnt == {ADDR_W{1'b1}}) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state == CLEAR);
    clr_we   = (state == CLEAR);
  end

  // Counter wraps to 0 on the last fill write, so IDLE always sees it at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clr_we) cnt <= cnt + 1'b1;
  end

  assign host_own = !clr_busy && host_en;
  assign spu_own  = !clr_busy && !host_en;
  assign dm_drop  = (dm_rd || dm_wr) && !spu_own;

  // Storage is deliberately never reset; an aborted fill leaves partial zeros.
  always_ff @(posedge clk) begin
    if (clr_we)                   mem[cnt]       <= '0;
    else if (host_own && host_wr) mem[host_addr] <= host_w_data;
    else if (spu_own && dm_wr)    mem[dm_addr]   <= dm_w_data;
  end

  // Nonblocking reads sample the pre-write word on a same-cycle read/write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_r_data <= '0;
    end else if (spu_own && dm_rd) begin
      dm_r_data <= mem[dm_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_r_data  <= '0;
      host_r_valid <= 1'b0;
    end else begin
      host_r_valid <= host_own && host_rd;
      if (host_own && host_rd) host_r_data <= mem[host_addr];
    end
  end

  // A new drop outranks a coincident clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          dm_err <= 1'b0;
    else if (dm_drop) dm_err <= 1'b1;
    else if (err_clr) dm_err <= 1'b0;
  end

endmodule

// File: tb/tb_spu_dmem.sv
// Directed bench for spu_dmem: stimulus pushes expected read data into
// queues, a monitor pops and compares as the DUT presents read results.
module tb_spu_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  dm_addr;
  logic        dm_rd;
  logic        dm_wr;
  logic [15:0] dm_w_data;
  logic [15:0] dm_r_data;
  logic        host_en;
  logic [7:0]  host_addr;
  logic        host_rd;
  logic        host_wr;
  logic [15:0] host_w_data;
  logic [15:0] host_r_data;
  logic        host_r_valid;
  logic        clr_req;
  logic        clr_busy;
  logic        dm_err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;
  logic [15:0] host_q[$];
  logic [15:0] dm_q[$];

  spu_dmem dut (
    .clk(clk), .rst(rst),
    .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr),
    .dm_w_data(dm_w_data), .dm_r_data(dm_r_data),
    .host_en(host_en), .host_addr(host_addr), .host_rd(host_rd),
    .host_wr(host_wr), .host_w_data(host_w_data),
    .host_r_data(host_r_data), .host_r_valid(host_r_valid),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .dm_err(dm_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [15:0] d);
    host_en = 1'b1; host_addr = a; host_w_data = d; host_wr = 1'b1;
    tick();
    host_wr = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, input logic [15:0] exp);
    host_en = 1'b1; host_addr = a; host_rd = 1'b1;
    host_q.push_back(exp);
    tick();
    host_rd = 1'b0;
  endtask

  task automatic spu_read(input logic [7:0] a, input logic [15:0] exp);
    dm_addr = a; dm_rd = 1'b1;
    tick();
    dm_rd = 1'b0;
    dm_q.push_back(exp);
  endtask

  // Monitor: compares every presented read result against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (host_r_valid) begin
        if (host_q.size() == 0) check("host_r_valid_extra", host_r_valid, 1'b0);
        else                    check("host_r_data", host_r_data, host_q.pop_front());
      end
      if (dm_q.size() > 0) check("dm_r_data", dm_r_data, dm_q.pop_front());
    end
  end

  initial begin
    int busy_cnt;
    rst = 1'b1; dm_addr = '0; dm_rd = 0; dm_wr = 0; dm_w_data = '0;
    host_en = 0; host_addr = '0; host_rd = 0; host_wr = 0; host_w_data = '0;
    clr_req = 0; err_clr = 0;
    tick(); tick();
    check("rst_dm_r_data", dm_r_data, 16'h0);
    check("rst_host_r_data", host_r_data, 16'h0);
    check("rst_host_r_valid", host_r_valid, 1'b0);
    check("rst_clr_busy", clr_busy, 1'b0);
    check("rst_dm_err", dm_err, 1'b0);
    rst = 1'b0;
    tick();

    // Basic host write, spu read
    host_write(8'd0, 16'h0005);
    host_write(8'd1, 16'h0007);
    host_en = 1'b0;
    spu_read(8'd0, 16'h0005);
    spu_read(8'd1, 16'h0007);

    // Spu read-before-write on the same address
    host_write(8'd10, 16'h1234);
    host_en = 1'b0;
    dm_addr = 8'd10; dm_w_data = 16'h002f; dm_wr = 1'b1; dm_rd = 1'b1;
    tick();
    dm_wr = 1'b0; dm_rd = 1'b0;
    dm_q.push_back(16'h1234);
    tick();
    spu_read(8'd10, 16'h002f);

    // Dropped spu accesses while host owns the memory
    host_write(8'd13, 16'h0abc);
    dm_addr = 8'd13; dm_w_data = 16'h00ff; dm_wr = 1'b1; dm_rd = 1'b1;
    tick();
    dm_wr = 1'b0; dm_rd = 1'b0;
    check("drop_dm_err_set", dm_err, 1'b1);
    check("drop_dm_r_hold", dm_r_data, 16'h002f);
    dm_wr = 1'b1; err_clr = 1'b1;
    tick();
    dm_wr = 1'b0;
    check("err_set_wins", dm_err, 1'b1);
    tick();
    err_clr = 1'b0;
    check("err_clr", dm_err, 1'b0);
    host_read(8'd13, 16'h0abc);

    // Host read-before-write, then ignored reads with host_en=0
    host_write(8'd20, 16'h1111);
    host_addr = 8'd20; host_w_data = 16'h2222; host_wr = 1'b1; host_rd = 1'b1;
    host_q.push_back(16'h1111);
    tick();
    host_wr = 1'b0; host_rd = 1'b0;
    host_read(8'd20, 16'h2222);
    host_en = 1'b0; host_addr = 8'd20; host_rd = 1'b1; host_wr = 1'b1;
    host_w_data = 16'h3333;
    tick();
    host_rd = 1'b0; host_wr = 1'b0;
    check("host_en0_no_valid", host_r_valid, 1'b0);
    host_read(8'd20, 16'h2222);

    // Full zero-fill of a memory preloaded with 0xffff
    for (int i = 0; i < 256; i++) host_write(i[7:0], 16'hffff);
    host_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0;
    while (clr_busy && busy_cnt < 300) begin
      busy_cnt++;
      if (busy_cnt == 10) begin
        host_en = 1'b1; host_addr = 8'd5; host_rd = 1'b1; clr_req = 1'b1;
      end
      if (busy_cnt == 13) begin
        host_rd = 1'b0; clr_req = 1'b0; host_en = 1'b0;
      end
      tick();
    end
    check("clr_busy_cycles", busy_cnt, 256);
    host_read(8'd0, 16'h0000);
    host_read(8'd128, 16'h0000);
    host_read(8'd255, 16'h0000);
    host_read(8'd5, 16'h0000);

    // Reset 100 cycles into a fill aborts it
    for (int i = 0; i < 256; i++) host_write(i[7:0], 16'hffff);
    host_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    rst = 1'b1;
    #1;
    check("rst_abort_clr_busy", clr_busy, 1'b0);
    check("rst_abort_dm_err", dm_err, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    host_read(8'd98, 16'h0000);
    host_read(8'd99, 16'h0000);
    host_read(8'd100, 16'hffff);
    host_read(8'd101, 16'hffff);
    host_en = 1'b0;

    tick(); tick(); tick();
    check("host_q_drained", host_q.size(), 0);
    check("dm_q_drained", dm_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spu_dmem.md
SPU_DMEM -- requirements
Module: spu_dmem

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-002 clk  input  1  rising-edge system clock shared with spu.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 dm_addr  input  8  spu data-memory word address.
REQ-005 dm_rd  input  1  spu read enable.
REQ-006 dm_wr  input  1  spu write enable.
REQ-007 dm_w_data  input  16  spu write data.
REQ-008 dm_r_data  output  16  spu read data.
REQ-009 host_en  input  1  host owns the memory; spu accesses are ignored.
REQ-010 host_addr  input  8  host word address.
REQ-011 host_rd  input  1  host read enable.
REQ-012 host_wr  input  1  host write enable.
REQ-013 host_w_data  input  16  host write data.
REQ-014 host_r_data  output  16  host read data.
REQ-015 host_r_valid  output  1  one-cycle pulse: host_r_data updated.
REQ-016 clr_req  input  1  request a zero-fill of all 256 words.
REQ-017 clr_busy  output  1  zero-fill in progress.
REQ-018 dm_err  output  1  sticky flag: an spu access was dropped.
REQ-019 err_clr  input  1  clears dm_err.

Function
REQ-020 Storage SHALL be 256 x 16-bit words; all addresses valid, no wrap or aliasing.
REQ-021 The FSM SHALL have two states: IDLE and CLEAR.
REQ-022 Access priority per cycle SHALL be CLEAR, then host (host_en=1), then spu.
REQ-023 Spu read, owned by spu: dm_rd=1 at edge N SHALL load MEM[dm_addr] into dm_r_data at edge N; the value is visible in cycle N+1 and held until the next accepted read (latency 1).
REQ-024 Spu write, owned by spu: dm_wr=1 at edge N SHALL write dm_w_data to MEM[dm_addr] at edge N.
REQ-025 If dm_rd and dm_wr are both 1 to the same address, the read SHALL return the pre-write data and the write SHALL complete.
REQ-026 Host read: host_rd=1 with host_en=1 SHALL update host_r_data with 1-cycle latency and pulse host_r_valid for exactly one cycle.
REQ-027 If host_rd and host_wr are both 1, the host SHALL see read-before-write, matching REQ-025.
REQ-028 Host accesses with host_en=0 SHALL be ignored silently.
REQ-029 If dm_rd or dm_wr is 1 while the spu does not own the memory (host_en=1 or CLEAR), the access SHALL be dropped, dm_r_data SHALL hold its value, and dm_err SHALL set on the next edge.
REQ-030 dm_err SHALL clear when err_clr=1; if err_clr coincides with a new drop, set SHALL win.
REQ-031 In IDLE, clr_req=1 SHALL enter CLEAR on the next edge with an 8-bit counter at 0.
REQ-032 In CLEAR, each cycle SHALL write 0 to MEM[counter] and increment the counter; after writing address 255 the counter SHALL wrap to 0 and the FSM SHALL return to IDLE.
REQ-033 clr_busy SHALL be 1 for exactly 256 cycles per clear; clr_req during CLEAR SHALL be ignored.
REQ-034 Host reads during CLEAR SHALL be dropped with no host_r_valid pulse.

Reset
REQ-035 rst=1 SHALL immediately force: FSM to IDLE, counter 0, dm_r_data 0, host_r_data 0, host_r_valid 0, clr_busy 0, dm_err 0.
REQ-036 Memory contents SHALL NOT be reset; reset during CLEAR SHALL abort the fill and leave words already zeroed as zero and the rest unchanged.

Verification
REQ-037 Host writes MEM[0]=0x0005 and MEM[1]=0x0007, then sets host_en=0; spu reads addr 0 then 1 -> dm_r_data is 0x0005 one cycle after the first read and 0x0007 one cycle after the second.
REQ-038 MEM[10]=0x1234; spu drives dm_rd=1, dm_wr=1, addr 10, data 0x002f -> dm_r_data=0x1234; a following read returns 0x002f.
REQ-039 host_en=1 while spu writes 0x00ff to addr 13 -> MEM[13] unchanged, dm_err=1; err_clr -> dm_err=0.
REQ-040 Preload all words with 0xffff, pulse clr_req -> clr_busy high for exactly 256 cycles; host reads of addr 0, 128 and 255 afterwards return 0x0000.
REQ-041 Assert rst 100 cycles into a clear -> clr_busy=0 immediately; addr 99 reads 0x0000 and addr 100 reads 0xffff.
REQ-042 Host read with host_en=1 -> host_r_valid pulses for one cycle only; issuing the same read with host_en=0 or during CLEAR produces no pulse.
